sa_beat_packer: RTL and testbench
=================================

Name: sa_beat_packer

Overview:
- Transmit side of the systolic-array input stream.
- Joins an A-row stream (N lanes) and a B-column stream (M lanes) into DATA_WIDTH beats; tags each beat with SOB/EOB block flags in the top two bits.
- Drives the array wrapper's slave rts/rtr interface with a one-entry registered output stage.
- Sits between the host DMA unpacker and the array wrapper.

Parameters:
- DATA_WIDTH, 1024, beat width.
- ARITH_IN_WIDTH, 64, element width.
- N, 8, A lanes per beat.
- M, 7, B lanes per beat. Elaboration error unless (N+M)*ARITH_IN_WIDTH <= DATA_WIDTH-2.
- CNT_WIDTH, 16, width of the k and block counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse; latches cfg and begins a job. Ignored unless IDLE.
- cfg_k_len_i  in  CNT_WIDTH  beats per block (K).
- cfg_blocks_i  in  CNT_WIDTH  blocks per job (B).
- a_valid_i  in  1  A beat valid.
- a_ready_o  out  1  A beat accepted.
- a_data_i  in  N*ARITH_IN_WIDTH  A row.
- b_valid_i  in  1  B beat valid.
- b_ready_o  out  1  B beat accepted.
- b_data_i  in  M*ARITH_IN_WIDTH  B column slice.
- rts_o  out  1  output beat valid.
- rtr_i  in  1  downstream ready.
- sow_o  out  1  first beat of job, qualified by rts_o.
- eow_o  out  1  last beat of job, qualified by rts_o.
- data_o  out  DATA_WIDTH  packed beat.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle pulse when the last beat is accepted downstream.
- err_o  out  1  sticky; set when start_i arrives with K==0 or B==0. Cleared by the next valid start.

Behaviour:
Reset values:
- All outputs 0.
- FSM in IDLE; counters 0; output register empty.

FSM states:
- IDLE:
  - start_i with K>0 and B>0 → RUN; latch K and B; k_cnt=0, blk_cnt=0.
  - start_i with K==0 or B==0 → stay IDLE; err_o=1; done_o pulses next cycle.
- RUN:
  - Join: a fire and b fire occur in the same cycle only, when a_valid_i & b_valid_i & out_free.
  - out_free = !rts_o | rtr_i.
  - a_ready_o = b_ready_o = RUN & out_free & a_valid_i & b_valid_i. Neither input is ever consumed alone.
  - On fire, the output register loads with:
    - data_o[N*W-1:0] = a_data_i
    - data_o[(N+M)*W-1:N*W] = b_data_i
    - bit DATA_WIDTH-2 = SOB = (k_cnt==0)
    - bit DATA_WIDTH-1 = EOB = (k_cnt==K-1)
    - all other bits 0
    - rts_o=1; sow_o = (k_cnt==0 & blk_cnt==0); eow_o = (EOB & blk_cnt==B-1).
  - k_cnt wraps to 0 at K-1 and blk_cnt increments.
  - After the fire that loads the final beat → DRAIN. No further input fires.
- DRAIN:
  - On rts_o & rtr_i → IDLE; done_o pulses in the same cycle as that acceptance; busy_o drops the next cycle.

Handshake and latency:
- Latency is 1 cycle from input fire to rts_o.
- Full throughput of 1 beat/cycle while rtr_i is held high.
- While rts_o & !rtr_i, data_o, sow_o and eow_o are held stable.
- A fire and a downstream acceptance in the same cycle are legal; the register reloads.
- When rts_o=0, data_o is driven to all zeros.
- K==1: SOB and EOB are both set on every beat.
- busy_o = (state != IDLE).
- rst_n asserted mid-job: the job aborts immediately, rts_o drops, no done_o pulse.

Optional Feature:
- Macro SA_PACKER_STATS_EN.
- Defined:
  - Adds outputs stat_beats_o [31:0], counting accepted output beats.
  - Adds stat_stalls_o [31:0], counting cycles with rts_o & !rtr_i.
  - Both clear on a valid start_i, saturate at all-ones, and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package sa_pkg:
  - ARITH_IN_WIDTH, N, M.
  - EOB_BIT and SOB_BIT offsets relative to DATA_WIDTH.
  - Packer state enum {IDLE, RUN, DRAIN}.
  - A helper function that packs a beat.
- Sub-module sa_out_reg: one-entry valid/ready register with hold on stall, instantiated once.

Test Plan:
1. K=3, B=2, both inputs always valid, rtr_i=1:
   - 6 beats on consecutive cycles.
   - SOB on beats 0 and 3; EOB on beats 2 and 5.
   - sow_o on beat 0; eow_o on beat 5.
   - done_o pulses with beat 5; A lanes in [511:0], B lanes in [959:512].
2. K=1, B=4:
   - 4 beats, each with both bit 1023 and bit 1022 set; done_o after the 4th.
3. K=4, B=1, rtr_i low for 5 cycles after beat 1:
   - data_o and rts_o stable during the stall.
   - a_ready_o=b_ready_o=0 during the stall.
   - No beat lost or duplicated; order preserved.
4. a_valid_i high, b_valid_i low for 3 cycles:
   - a_ready_o stays 0 and no beat is produced.
   - When b_valid_i rises, the beat fires that cycle.
5. start_i with cfg_k_len_i=0:
   - err_o=1, done_o pulses, no rts_o.
   - A following start with K=2, B=1 clears err_o and emits 2 beats.
6. rst_n asserted after beat 2 of a K=8 job:
   - All outputs 0 immediately; no done_o.
   - A new start emits sow_o on its first beat.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array input beat packer: default
// geometry, block-flag bit offsets, the packer state encoding and the
// beat packing helper.
package sa_pkg;

  localparam int DATA_WIDTH     = 1024;
  localparam int ARITH_IN_WIDTH = 64;
  localparam int N              = 8;
  localparam int M              = 7;
  localparam int CNT_WIDTH      = 16;

  // Block flags live in the top two bits of a beat: EOB at DATA_WIDTH-1,
  // SOB at DATA_WIDTH-2.
  localparam int EOB_OFS = 1;
  localparam int SOB_OFS = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pk_state_t;

  // A lanes fill the bottom of the beat, B lanes sit directly above them,
  // the two block flags take the top bits and everything else is zero.
  function automatic logic [DATA_WIDTH-1:0] pack_beat(
    input logic [N*ARITH_IN_WIDTH-1:0] a_row,
    input logic [M*ARITH_IN_WIDTH-1:0] b_col,
    input logic                        sob,
    input logic                        eob
  );
    logic [DATA_WIDTH-1:0] beat;
    beat = '0;
    beat[N*ARITH_IN_WIDTH-1:0] = a_row;
    beat[(N+M)*ARITH_IN_WIDTH-1 -: M*ARITH_IN_WIDTH] = b_col;
    beat[DATA_WIDTH-SOB_OFS] = sob;
    beat[DATA_WIDTH-EOB_OFS] = eob;
    return beat;
  endfunction

endpackage

// File: rtl/sa_beat_packer_if.sv
// Output beat stream of the packer towards the array wrapper (rts/rtr).
interface sa_beat_packer_if #(
  parameter int DATA_WIDTH = 1024
);
  logic                  rts_o;
  logic                  rtr_i;
  logic                  sow_o;
  logic                  eow_o;
  logic [DATA_WIDTH-1:0] data_o;

  modport master (output rts_o, output sow_o, output eow_o, output data_o, input rtr_i);
  modport slave  (input rts_o, input sow_o, input eow_o, input data_o, output rtr_i);
endinterface

// File: rtl/sa_out_reg.sv
// One-entry valid/ready output register. Holds its contents while the
// consumer stalls, accepts a new load in the same cycle as an acceptance,
// and clears its payload when it empties so an idle output reads zero.
module sa_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         rtr_i,
  output logic         valid_o,
  output logic         free_o,
  output logic [W-1:0] data_o
);

  logic         valid_reg;
  logic [W-1:0] data_reg;

  // Load wins over drain so a fire and an acceptance in one cycle reloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (load_i) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data_i;
    end else if (rtr_i) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end
  end

  assign valid_o = valid_reg;
  assign free_o  = !valid_reg | rtr_i;
  assign data_o  = data_reg;

endmodule

// File: rtl/sa_beat_packer.sv
// Transmit side of the systolic-array input stream: joins an A-row stream
// and a B-column stream into tagged beats (SOB/EOB in the top two bits)
// and presents them through a one-entry registered rts/rtr stage.
// Optional statistics counters are built when SA_PACKER_STATS_EN is defined.
module sa_beat_packer
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH     = sa_pkg::DATA_WIDTH,
  parameter int ARITH_IN_WIDTH = sa_pkg::ARITH_IN_WIDTH,
  parameter int N              = sa_pkg::N,
  parameter int M              = sa_pkg::M,
  parameter int CNT_WIDTH      = sa_pkg::CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic [CNT_WIDTH-1:0]        cfg_k_len_i,
  input  logic [CNT_WIDTH-1:0]        cfg_blocks_i,
  input  logic                        a_valid_i,
  output logic                        a_ready_o,
  input  logic [N*ARITH_IN_WIDTH-1:0] a_data_i,
  input  logic                        b_valid_i,
  output logic                        b_ready_o,
  input  logic [M*ARITH_IN_WIDTH-1:0] b_data_i,
  sa_beat_packer_if.master            out_if,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
`ifdef SA_PACKER_STATS_EN
  ,
  output logic [31:0]                 stat_beats_o,
  output logic [31:0]                 stat_stalls_o
`endif
);

  // The lanes plus both flag bits must fit in a beat, and the packing
  // helper is sized from the package geometry.
  if ((N + M) * ARITH_IN_WIDTH > DATA_WIDTH - 2) begin : g_bad_width
    $error("sa_beat_packer: (N+M)*ARITH_IN_WIDTH exceeds DATA_WIDTH-2");
  end
  if (DATA_WIDTH != sa_pkg::DATA_WIDTH || ARITH_IN_WIDTH != sa_pkg::ARITH_IN_WIDTH ||
      N != sa_pkg::N || M != sa_pkg::M) begin : g_bad_geom
    $error("sa_beat_packer: geometry must match sa_pkg");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  pk_state_t            state_reg;
  logic [CNT_WIDTH-1:0] k_len_reg;
  logic [CNT_WIDTH-1:0] blocks_reg;
  logic [CNT_WIDTH-1:0] k_cnt_reg;
  logic [CNT_WIDTH-1:0] blk_cnt_reg;
  logic                 err_reg;
  logic                 err_done_reg;

  logic                    out_free;
  logic                    out_valid;
  logic                    fire;
  logic                    accept;
  logic                    k_last;
  logic                    blk_last;
  logic                    cfg_ok;
  logic [DATA_WIDTH-1:0]   beat_next;
  logic [DATA_WIDTH+1:0]   load_data;
  logic [DATA_WIDTH+1:0]   out_q;

  assign cfg_ok   = (cfg_k_len_i != '0) && (cfg_blocks_i != '0);
  assign k_last   = (k_cnt_reg == k_len_reg - CNT_ONE);
  assign blk_last = (blk_cnt_reg == blocks_reg - CNT_ONE);

  // Both inputs are consumed together or not at all.
  assign fire      = (state_reg == RUN) & a_valid_i & b_valid_i & out_free;
  assign a_ready_o = fire;
  assign b_ready_o = fire;

  assign beat_next = pack_beat(a_data_i, b_data_i, k_cnt_reg == '0, k_last);
  assign load_data = {(k_cnt_reg == '0) && (blk_cnt_reg == '0), k_last & blk_last, beat_next};

  sa_out_reg #(
    .W (DATA_WIDTH + 2)
  ) u_out_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (fire),
    .load_data_i (load_data),
    .rtr_i       (out_if.rtr_i),
    .valid_o     (out_valid),
    .free_o      (out_free),
    .data_o      (out_q)
  );

  assign out_if.rts_o  = out_valid;
  assign out_if.sow_o  = out_q[DATA_WIDTH+1];
  assign out_if.eow_o  = out_q[DATA_WIDTH];
  assign out_if.data_o = out_q[DATA_WIDTH-1:0];

  assign accept = out_valid & out_if.rtr_i;
  assign busy_o = (state_reg != IDLE);
  assign err_o  = err_reg;
  // A rejected start reports done a cycle later; a real job reports done
  // in the very cycle its final beat is taken.
  assign done_o = err_done_reg | ((state_reg == DRAIN) & accept);

  // Job sequencing: configuration latch, k/block counters, drain of the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      k_len_reg    <= '0;
      blocks_reg   <= '0;
      k_cnt_reg    <= '0;
      blk_cnt_reg  <= '0;
      err_reg      <= 1'b0;
      err_done_reg <= 1'b0;
    end else begin
      err_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            if (cfg_ok) begin
              err_reg     <= 1'b0;
              k_len_reg   <= cfg_k_len_i;
              blocks_reg  <= cfg_blocks_i;
              k_cnt_reg   <= '0;
              blk_cnt_reg <= '0;
              state_reg   <= RUN;
            end else begin
              err_reg      <= 1'b1;
              err_done_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          if (fire) begin
            if (k_last) begin
              k_cnt_reg   <= '0;
              blk_cnt_reg <= blk_cnt_reg + CNT_ONE;
            end else begin
              k_cnt_reg <= k_cnt_reg + CNT_ONE;
            end
            if (k_last && blk_last) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (accept) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef SA_PACKER_STATS_EN
  logic [31:0] stat_beats_reg;
  logic [31:0] stat_stalls_reg;

  // Saturating counts of accepted beats and stalled cycles, cleared per job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats_reg  <= '0;
      stat_stalls_reg <= '0;
    end else if ((state_reg == IDLE) && start_i && cfg_ok) begin
      stat_beats_reg  <= '0;
      stat_stalls_reg <= '0;
    end else begin
      if (accept && (stat_beats_reg != '1)) begin
        stat_beats_reg <= stat_beats_reg + 32'd1;
      end
      if (out_valid && !out_if.rtr_i && (stat_stalls_reg != '1)) begin
        stat_stalls_reg <= stat_stalls_reg + 32'd1;
      end
    end
  end

  assign stat_beats_o  = stat_beats_reg;
  assign stat_stalls_o = stat_stalls_reg;
`endif

endmodule

// File: tb/tb_sa_beat_packer.sv
// Directed bench for sa_beat_packer: streaming jobs checked against a
// beat scoreboard, join behaviour, config errors and mid-job reset.
module tb_sa_beat_packer;
  import sa_pkg::*;

  localparam int DW = sa_pkg::DATA_WIDTH;
  localparam int W  = sa_pkg::ARITH_IN_WIDTH;
  localparam int AW = sa_pkg::N * W;
  localparam int BW = sa_pkg::M * W;
  localparam int CW = sa_pkg::CNT_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [CW-1:0] cfg_k_len_i = '0;
  logic [CW-1:0] cfg_blocks_i = '0;
  logic          a_valid_i = 1'b0;
  logic          a_ready_o;
  logic [AW-1:0] a_data_i = '0;
  logic          b_valid_i = 1'b0;
  logic          b_ready_o;
  logic [BW-1:0] b_data_i = '0;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
`ifdef SA_PACKER_STATS_EN
  logic [31:0]   stat_beats_o;
  logic [31:0]   stat_stalls_o;
`endif

  int vecs = 0;
  int miscompares = 0;

  sa_beat_packer_if #(.DATA_WIDTH(DW)) pk_if ();

  sa_beat_packer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .cfg_k_len_i  (cfg_k_len_i),
    .cfg_blocks_i (cfg_blocks_i),
    .a_valid_i    (a_valid_i),
    .a_ready_o    (a_ready_o),
    .a_data_i     (a_data_i),
    .b_valid_i    (b_valid_i),
    .b_ready_o    (b_ready_o),
    .b_data_i     (b_data_i),
    .out_if       (pk_if),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
`ifdef SA_PACKER_STATS_EN
    ,
    .stat_beats_o  (stat_beats_o),
    .stat_stalls_o (stat_stalls_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] a_pat(input int idx);
    logic [AW-1:0] v;
    for (int j = 0; j < sa_pkg::N; j++) v[j*W +: W] = {32'hA11A_0000 | 32'(idx), 32'(j)};
    return v;
  endfunction

  function automatic logic [BW-1:0] b_pat(input int idx);
    logic [BW-1:0] v;
    for (int j = 0; j < sa_pkg::M; j++) v[j*W +: W] = {32'hB22B_0000 | 32'(idx), 32'(j + 100)};
    return v;
  endfunction

  // Expected beat idx of a job with K beats per block.
  function automatic logic [DW-1:0] exp_beat(input int idx, input int k);
    logic [DW-1:0] d;
    d = '0;
    d[AW-1:0]       = a_pat(idx);
    d[AW+BW-1:AW]   = b_pat(idx);
    d[DW-2]         = ((idx % k) == 0);
    d[DW-1]         = ((idx % k) == (k - 1));
    return d;
  endfunction

  // Pulse start for one cycle; returns at posedge+1 with start low.
  task automatic do_start(input int k, input int nb);
    start_i      = 1'b1;
    cfg_k_len_i  = CW'(k);
    cfg_blocks_i = CW'(nb);
    a_valid_i    = 1'b0;
    b_valid_i    = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Stream a whole job with both inputs always offered; optional stall of
  // stall_len cycles on rtr_i right after beat stall_after is accepted.
  task automatic run_stream(input string name, input int k, input int nb,
                            input int stall_after, input int stall_len);
    int total = k * nb;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int stall_left = 0;
    logic fired;
    logic exp_rdy;
    logic exp_done;
    do_start(k, nb);
    while (got < total && cyc < 200) begin
      a_valid_i = (sent < total);
      b_valid_i = (sent < total);
      a_data_i  = a_pat(sent);
      b_data_i  = b_pat(sent);
      pk_if.rtr_i = (stall_left == 0);
      @(negedge clk);
      cyc++;
      fired    = a_ready_o;
      exp_rdy  = (sent < total) && (!pk_if.rts_o || pk_if.rtr_i);
      exp_done = pk_if.rts_o && pk_if.rtr_i && (got == total - 1);
      vecs++;
      if (a_ready_o !== exp_rdy || b_ready_o !== exp_rdy) begin
        $display("FAIL %s ready cyc%0d: a=%b b=%b want %b", name, cyc, a_ready_o, b_ready_o, exp_rdy);
        miscompares++;
      end
      vecs++;
      if (done_o !== exp_done) begin
        $display("FAIL %s done cyc%0d: got %b want %b", name, cyc, done_o, exp_done);
        miscompares++;
      end
      if (!pk_if.rtr_i) begin
        vecs++;
        if (pk_if.rts_o !== 1'b1 || pk_if.data_o !== exp_beat(got, k)) begin
          $display("FAIL %s stall hold cyc%0d: rts=%b data=%h want rts=1 data=%h", name, cyc,
                   pk_if.rts_o, pk_if.data_o, exp_beat(got, k));
          miscompares++;
        end
        stall_left--;
      end else if (pk_if.rts_o) begin
        vecs++;
        if (pk_if.data_o !== exp_beat(got, k) || pk_if.sow_o !== (got == 0) ||
            pk_if.eow_o !== (got == total - 1)) begin
          $display("FAIL %s beat%0d: data=%h sow=%b eow=%b want data=%h sow=%b eow=%b", name, got,
                   pk_if.data_o, pk_if.sow_o, pk_if.eow_o, exp_beat(got, k), got == 0, got == total - 1);
          miscompares++;
        end
        $display("%s beat %0d accepted cyc %0d sob=%b eob=%b", name, got, cyc,
                 pk_if.data_o[DW-2], pk_if.data_o[DW-1]);
        got++;
        if (got == stall_after + 1) stall_left = stall_len;
      end else begin
        vecs++;
        if (pk_if.data_o !== '0) begin
          $display("FAIL %s idle data cyc%0d: got %h want 0", name, cyc, pk_if.data_o);
          miscompares++;
        end
      end
      @(posedge clk); #1;
      if (fired) sent++;
    end
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    pk_if.rtr_i = 1'b1;
    vecs++;
    if (got != total) begin
      $display("FAIL %s beat count: got %0d want %0d", name, got, total);
      miscompares++;
    end
    if (stall_len == 0) begin
      vecs++;
      if (cyc != total + 1) begin
        $display("FAIL %s throughput cycles: got %0d want %0d", name, cyc, total + 1);
        miscompares++;
      end
    end
    @(negedge clk);
    vecs++;
    if (busy_o !== 1'b0 || pk_if.rts_o !== 1'b0 || done_o !== 1'b0) begin
      $display("FAIL %s after job: busy=%b rts=%b done=%b want 0 0 0", name, busy_o, pk_if.rts_o, done_o);
      miscompares++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pk_if.rtr_i = 1'b1;
    @(negedge clk);
    vecs++;
    if (pk_if.rts_o !== 1'b0 || pk_if.sow_o !== 1'b0 || pk_if.eow_o !== 1'b0 || pk_if.data_o !== '0 ||
        busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 || a_ready_o !== 1'b0 || b_ready_o !== 1'b0) begin
      $display("FAIL reset outputs: rts=%b busy=%b done=%b err=%b ardy=%b want all 0",
               pk_if.rts_o, busy_o, done_o, err_o, a_ready_o);
      miscompares++;
    end
    $display("reset: outputs sampled");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    run_stream("k3b2", 3, 2, -1, 0);
  endtask

  task automatic test_k1();
    run_stream("k1b4", 1, 4, -1, 0);
  endtask

  task automatic test_stall();
    run_stream("k4b1stall", 4, 1, 1, 5);
  endtask

  task automatic test_join();
    do_start(2, 1);
    pk_if.rtr_i = 1'b1;
    a_data_i = a_pat(0);
    b_data_i = b_pat(0);
    for (int i = 0; i < 3; i++) begin
      a_valid_i = 1'b1;
      b_valid_i = 1'b0;
      @(negedge clk);
      vecs++;
      if (a_ready_o !== 1'b0 || b_ready_o !== 1'b0 || pk_if.rts_o !== 1'b0) begin
        $display("FAIL join wait%0d: ardy=%b brdy=%b rts=%b want 0 0 0", i, a_ready_o, b_ready_o, pk_if.rts_o);
        miscompares++;
      end
      $display("join: cycle %0d with b_valid low", i);
      @(posedge clk); #1;
    end
    b_valid_i = 1'b1;
    @(negedge clk);
    vecs++;
    if (a_ready_o !== 1'b1 || b_ready_o !== 1'b1) begin
      $display("FAIL join fire: ardy=%b brdy=%b want 1 1", a_ready_o, b_ready_o);
      miscompares++;
    end
    @(posedge clk); #1;
    a_data_i = a_pat(1);
    b_data_i = b_pat(1);
    @(negedge clk);
    vecs++;
    if (pk_if.rts_o !== 1'b1 || pk_if.data_o !== exp_beat(0, 2) || pk_if.sow_o !== 1'b1) begin
      $display("FAIL join beat0: rts=%b sow=%b data=%h want 1 1 %h", pk_if.rts_o, pk_if.sow_o,
               pk_if.data_o, exp_beat(0, 2));
      miscompares++;
    end
    @(posedge clk); #1;
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    @(negedge clk);
    vecs++;
    if (pk_if.data_o !== exp_beat(1, 2) || pk_if.eow_o !== 1'b1 || done_o !== 1'b1) begin
      $display("FAIL join beat1: eow=%b done=%b data=%h want 1 1 %h", pk_if.eow_o, done_o,
               pk_if.data_o, exp_beat(1, 2));
      miscompares++;
    end
    $display("join: beat 1 accepted, job done");
    @(posedge clk); #1;
  endtask

  task automatic test_cfg_err();
    do_start(0, 3);
    @(negedge clk);
    vecs++;
    if (err_o !== 1'b1 || done_o !== 1'b1 || pk_if.rts_o !== 1'b0 || busy_o !== 1'b0) begin
      $display("FAIL err k0: err=%b done=%b rts=%b busy=%b want 1 1 0 0", err_o, done_o, pk_if.rts_o, busy_o);
      miscompares++;
    end
    @(posedge clk); #1;
    @(negedge clk);
    vecs++;
    if (err_o !== 1'b1 || done_o !== 1'b0) begin
      $display("FAIL err sticky: err=%b done=%b want 1 0", err_o, done_o);
      miscompares++;
    end
    $display("cfg_err: K=0 rejected");
    @(posedge clk); #1;
    do_start(2, 0);
    @(negedge clk);
    vecs++;
    if (err_o !== 1'b1 || done_o !== 1'b1 || busy_o !== 1'b0) begin
      $display("FAIL err b0: err=%b done=%b busy=%b want 1 1 0", err_o, done_o, busy_o);
      miscompares++;
    end
    $display("cfg_err: B=0 rejected");
    @(posedge clk); #1;
    run_stream("k2b1", 2, 1, -1, 0);
    @(negedge clk);
    vecs++;
    if (err_o !== 1'b0) begin
      $display("FAIL err clear: got %b want 0", err_o);
      miscompares++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    do_start(8, 1);
    pk_if.rtr_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_valid_i = 1'b1;
      b_valid_i = 1'b1;
      a_data_i  = a_pat(i);
      b_data_i  = b_pat(i);
      @(posedge clk); #1;
    end
    a_data_i = a_pat(3);
    b_data_i = b_pat(3);
    @(negedge clk);
    vecs++;
    if (pk_if.rts_o !== 1'b1 || pk_if.data_o !== exp_beat(2, 8)) begin
      $display("FAIL abort beat2: rts=%b data=%h want 1 %h", pk_if.rts_o, pk_if.data_o, exp_beat(2, 8));
      miscompares++;
    end
    #1 rst_n = 1'b0;
    #1;
    vecs++;
    if (pk_if.rts_o !== 1'b0 || pk_if.data_o !== '0 || pk_if.sow_o !== 1'b0 || pk_if.eow_o !== 1'b0 ||
        busy_o !== 1'b0 || done_o !== 1'b0 || a_ready_o !== 1'b0 || b_ready_o !== 1'b0) begin
      $display("FAIL abort outputs: rts=%b busy=%b done=%b ardy=%b want all 0", pk_if.rts_o, busy_o,
               done_o, a_ready_o);
      miscompares++;
    end
    $display("abort: reset asserted mid-job");
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    vecs++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      $display("FAIL abort post: done=%b busy=%b want 0 0", done_o, busy_o);
      miscompares++;
    end
    @(posedge clk); #1;
    run_stream("k2b1_after_abort", 2, 1, -1, 0);
  endtask

  initial begin
    pk_if.rtr_i = 1'b1;
    test_reset();
    test_stream();
    test_k1();
    test_stall();
    test_join();
    test_cfg_err();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
